// File: rtl/lcd_renderizador.sv
// HD44780 renderer: runs the LCD power-on/init sequence, then on each send pulse
// formats the latched opcode, register index and signed result as two 16-char lines.
module lcd_renderizador #(
  parameter int T_POWERON = 1000000,
  parameter int T_E       = 12,
  parameter int T_CMD     = 2500,
  parameter int T_CLR     = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_send,
  input  logic [2:0]  op_selc,
  input  logic [3:0]  logger,
  input  logic [15:0] result,
  output logic        busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);

  localparam int CW = $clog2(T_POWERON + T_E + T_CMD + T_CLR + 16 + 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] POWERON_LAST = CW'(T_POWERON - 1);
  localparam logic [CW-1:0] E_LAST       = CW'(T_E - 1);
  localparam logic [CW-1:0] CMD_LAST     = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_LAST     = CW'(T_CLR - 1);
  localparam logic [CW-1:0] CONV_LAST    = CW'(15);

  typedef enum logic [2:0] {S_POWERON, S_INIT, S_IDLE, S_CONV, S_WRITE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_ELOW} phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    idx_q;
  logic [2:0]    op_q, sh_op_q;
  logic [3:0]    lg_q, sh_lg_q;
  logic [15:0]   res_q, sh_res_q;
  logic          pending_q;
  logic [15:0]   bin_q;
  logic [19:0]   bcd_q;
  logic          busy_q, e_q, rs_q;
  logic [7:0]    data_q;

  function automatic logic [7:0] init_byte(input logic [5:0] idx);
    case (idx)
      6'd0:    init_byte = 8'h38;
      6'd1:    init_byte = 8'h0C;
      6'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  function automatic logic [31:0] mnemonic(input logic [2:0] op);
    case (op)
      3'd0:    mnemonic = "LOAD";
      3'd1:    mnemonic = "ADD ";
      3'd2:    mnemonic = "ADDI";
      3'd3:    mnemonic = "SUB ";
      3'd4:    mnemonic = "SUBI";
      3'd5:    mnemonic = "MUL ";
      3'd6:    mnemonic = "CLR ";
      default: mnemonic = "DPL ";
    endcase
  endfunction

  function automatic logic [7:0] line1_char(input logic [3:0] col, input logic [2:0] op,
                                            input logic [3:0] lg);
    logic [31:0] m;
    m = mnemonic(op);
    case (col)
      4'd0:    line1_char = m[31:24];
      4'd1:    line1_char = m[23:16];
      4'd2:    line1_char = m[15:8];
      4'd3:    line1_char = m[7:0];
      4'd5:    line1_char = 8'h5B;
      4'd6:    line1_char = 8'h30 + {7'd0, lg[3]};
      4'd7:    line1_char = 8'h30 + {7'd0, lg[2]};
      4'd8:    line1_char = 8'h30 + {7'd0, lg[1]};
      4'd9:    line1_char = 8'h30 + {7'd0, lg[0]};
      4'd10:   line1_char = 8'h5D;
      default: line1_char = 8'h20;
    endcase
  endfunction

  function automatic logic [7:0] line2_char(input logic [3:0] col, input logic neg,
                                            input logic [19:0] bcd);
    case (col)
      4'd0:    line2_char = neg ? 8'h2D : 8'h2B;
      4'd1:    line2_char = 8'h30 + {4'd0, bcd[19:16]};
      4'd2:    line2_char = 8'h30 + {4'd0, bcd[15:12]};
      4'd3:    line2_char = 8'h30 + {4'd0, bcd[11:8]};
      4'd4:    line2_char = 8'h30 + {4'd0, bcd[7:4]};
      4'd5:    line2_char = 8'h30 + {4'd0, bcd[3:0]};
      default: line2_char = 8'h20;
    endcase
  endfunction

  // {rs, data} at frame position idx: 0x80, 16 chars, 0xC0, 16 chars
  function automatic logic [8:0] frame_byte(input logic [5:0] idx, input logic [2:0] op,
                                            input logic [3:0] lg, input logic neg,
                                            input logic [19:0] bcd);
    logic [5:0] c1, c2;
    c1 = idx - 6'd1;
    c2 = idx - 6'd18;
    if (idx == 6'd0)       frame_byte = 9'h080;
    else if (idx < 6'd17)  frame_byte = {1'b1, line1_char(c1[3:0], op, lg)};
    else if (idx == 6'd17) frame_byte = 9'h0C0;
    else                   frame_byte = {1'b1, line2_char(c2[3:0], neg, bcd)};
  endfunction

  // Negation is done in 17 bits so that 0x8000 yields 32768
  function automatic logic [15:0] magnitude(input logic [15:0] v);
    logic [16:0] sext;
    sext = {v[15], v};
    if (v[15]) sext = ~sext + 17'd1;
    magnitude = sext[15:0];
  endfunction

  logic [19:0]   bcd_adj;
  logic [35:0]   dd_shift;
  logic [5:0]    idx_next, last_idx;
  logic [8:0]    next_byte;
  logic [CW-1:0] low_last;
  logic [2:0]    src_op;
  logic [3:0]    src_lg;
  logic [15:0]   src_res;
  logic          in_byte_state, last_byte_done, do_load;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_shift = {bcd_adj, bin_q} << 1;

    idx_next  = idx_q + 6'd1;
    last_idx  = (state_q == S_INIT) ? 6'd3 : 6'd33;
    next_byte = (state_q == S_INIT) ? {1'b0, init_byte(idx_next)}
                                    : frame_byte(idx_next, op_q, lg_q, res_q[15], bcd_q);
    low_last  = (data_q == 8'h01 && !rs_q) ? CLR_LAST : CMD_LAST;

    // A pulse arriving on the very cycle a frame ends beats the older shadow copy
    src_op  = btn_send ? op_selc : sh_op_q;
    src_lg  = btn_send ? logger  : sh_lg_q;
    src_res = btn_send ? result  : sh_res_q;

    in_byte_state  = (state_q == S_INIT) || (state_q == S_WRITE);
    last_byte_done = in_byte_state && (phase_q == PH_ELOW) && (cnt_q == low_last) &&
                     (idx_q == last_idx);
    do_load = ((state_q == S_IDLE) && btn_send) ||
              (last_byte_done && (btn_send || pending_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_POWERON;
      phase_q   <= PH_SETUP;
      cnt_q     <= '0;
      idx_q     <= '0;
      op_q      <= '0;
      lg_q      <= '0;
      res_q     <= '0;
      sh_op_q   <= '0;
      sh_lg_q   <= '0;
      sh_res_q  <= '0;
      pending_q <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b1;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      if (btn_send && state_q != S_IDLE) begin
        sh_op_q   <= op_selc;
        sh_lg_q   <= logger;
        sh_res_q  <= result;
        pending_q <= 1'b1;
      end

      case (state_q)
        S_POWERON: begin
          if (cnt_q == POWERON_LAST) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= init_byte(6'd0);
            rs_q    <= 1'b0;
            phase_q <= PH_SETUP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_IDLE: ;
        S_CONV: begin
          {bcd_q, bin_q} <= dd_shift;
          if (cnt_q == CONV_LAST) begin
            state_q <= S_WRITE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= 8'h80;
            rs_q    <= 1'b0;
            phase_q <= PH_SETUP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          case (phase_q)
            PH_SETUP: begin
              e_q     <= 1'b1;
              cnt_q   <= '0;
              phase_q <= PH_EHIGH;
            end
            PH_EHIGH: begin
              if (cnt_q == E_LAST) begin
                e_q     <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PH_ELOW;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
            default: begin
              if (cnt_q == low_last) begin
                cnt_q <= '0;
                if (idx_q == last_idx) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end else begin
                  idx_q           <= idx_next;
                  {rs_q, data_q}  <= next_byte;
                  phase_q         <= PH_SETUP;
                end
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end
          endcase
        end
      endcase

      if (do_load) begin
        op_q      <= src_op;
        lg_q      <= src_lg;
        res_q     <= src_res;
        bin_q     <= magnitude(src_res);
        bcd_q     <= '0;
        cnt_q     <= '0;
        pending_q <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= S_CONV;
      end
    end
  end

  assign busy     = busy_q;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;

endmodule

// File: tb/tb_lcd_renderizador.sv
// Directed bench for lcd_renderizador: captures every byte latched by lcd_e and
// compares init sequences and rendered frames against hand-written expected text.
module tb_lcd_renderizador;
  localparam int T_POWERON = 100;
  localparam int T_E       = 2;
  localparam int T_CMD     = 5;
  localparam int T_CLR     = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_send = 1'b0;
  logic [2:0]  op_selc = '0;
  logic [3:0]  logger = '0;
  logic [15:0] result = '0;
  logic        busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_renderizador #(.T_POWERON(T_POWERON), .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR)) dut (
    .clk(clk), .rst_n(rst_n), .btn_send(btn_send), .op_selc(op_selc), .logger(logger),
    .result(result), .busy(busy), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] got_q[$];
  int hi_q[$];
  int gap_q[$];
  int unstable_cnt = 0;

  // Byte monitor: logs {rs,data} on each E rise, E-high widths, and E-low gaps
  logic prev_e = 1'b0;
  logic [8:0] prev_bus = '0;
  int hi_len = 0;
  int low_len = 0;
  logic low_counting = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e = 1'b0;
      low_counting = 1'b0;
      hi_len = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        got_q.push_back({lcd_rs, lcd_data});
        if ({lcd_rs, lcd_data} !== prev_bus) unstable_cnt++;
        if (low_counting) gap_q.push_back(low_len);
        low_counting = 1'b0;
        hi_len = 1;
      end else if (lcd_e) begin
        hi_len++;
        if ({lcd_rs, lcd_data} !== prev_bus) unstable_cnt++;
      end else if (prev_e) begin
        hi_q.push_back(hi_len);
        if ({lcd_rs, lcd_data} !== prev_bus) unstable_cnt++;
        low_counting = 1'b1;
        low_len = 1;
      end else if (low_counting) begin
        if (busy === 1'b0) begin
          gap_q.push_back(low_len);
          low_counting = 1'b0;
        end else begin
          low_len++;
        end
      end
    end
    prev_e = lcd_e;
    prev_bus = {lcd_rs, lcd_data};
  end

  function automatic logic [305:0] pack_frame(input logic [127:0] l1, input logic [127:0] l2);
    logic [305:0] f;
    f = '0;
    f[305 -: 9] = 9'h080;
    for (int i = 0; i < 16; i++) f[296 - 9*i -: 9] = {1'b1, l1[127 - 8*i -: 8]};
    f[152 -: 9] = 9'h0C0;
    for (int i = 0; i < 16; i++) f[143 - 9*i -: 9] = {1'b1, l2[127 - 8*i -: 8]};
    return f;
  endfunction

  task automatic pop_bytes(input int n, output logic [305:0] f);
    f = '0;
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0) f[305 - 9*i -: 9] = got_q.pop_front();
      else f[305 - 9*i -: 9] = 9'h1FF;
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    hi_q.delete();
    gap_q.delete();
  endtask

  task automatic pulse(input logic [2:0] op, input logic [3:0] lg, input logic [15:0] res);
    @(negedge clk);
    op_selc = op;
    logger = lg;
    result = res;
    btn_send = 1'b1;
    @(negedge clk);
    btn_send = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, budget);
    end
    @(negedge clk);
  endtask

  // Releases reset on a falling edge and counts samples until lcd_e first rises
  task automatic release_reset(output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  localparam logic [35:0] INIT_BYTES = {9'h038, 9'h00C, 9'h006, 9'h001};

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, lcd_e} !== 2'b10) begin
      failures++;
      $display("FAIL reset_ctl: busy,e=%b required 10", {busy, lcd_e});
    end
    checks++;
    if ({lcd_rs, lcd_rw, lcd_data} !== 10'h000) begin
      failures++;
      $display("FAIL reset_bus: rs,rw,data=%h required 000", {lcd_rs, lcd_rw, lcd_data});
    end
  endtask

  task automatic test_init();
    int n;
    logic [305:0] f;
    int exp_gap[4] = '{6, 6, 6, 20};
    int g;
    int bad_hi;
    clear_logs();
    release_reset(n);
    checks++;
    if (n !== T_POWERON + 1) begin
      failures++;
      $display("FAIL poweron_wait: first E at sample %0d, required %0d", n, T_POWERON + 1);
    end
    wait_idle(500, "init");
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL init_count: got %0d bytes, required 4", got_q.size());
    end
    pop_bytes(4, f);
    checks++;
    if (f[305 -: 36] !== INIT_BYTES) begin
      failures++;
      $display("FAIL init_bytes: got %h required %h", f[305 -: 36], INIT_BYTES);
    end
    bad_hi = 0;
    foreach (hi_q[i]) if (hi_q[i] != T_E) bad_hi++;
    checks++;
    if (hi_q.size() != 4 || bad_hi != 0) begin
      failures++;
      $display("FAIL init_e_width: %0d widths, %0d not equal to %0d", hi_q.size(), bad_hi, T_E);
    end
    for (int i = 0; i < 4; i++) begin
      g = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
      checks++;
      if (g != exp_gap[i]) begin
        failures++;
        $display("FAIL init_gap%0d: E low %0d cycles, required %0d", i, g, exp_gap[i]);
      end
    end
  endtask

  task automatic test_frame_add();
    logic [305:0] f, e;
    int bad_hi;
    clear_logs();
    pulse(3'b001, 4'b0101, 16'd42);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL add_busy: busy=%b after capture, required 1", busy);
    end
    wait_idle(2000, "add");
    e = pack_frame("ADD  [0101]     ", "+00042          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL add_frame: got %h required %h", f, e);
    end
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL add_extra: %0d extra bytes, required 0", got_q.size());
    end
    bad_hi = 0;
    foreach (hi_q[i]) if (hi_q[i] != T_E) bad_hi++;
    checks++;
    if (hi_q.size() != 34 || bad_hi != 0) begin
      failures++;
      $display("FAIL add_e_width: %0d widths, %0d not equal to %0d", hi_q.size(), bad_hi, T_E);
    end
    checks++;
    if (unstable_cnt != 0) begin
      failures++;
      $display("FAIL bus_stable: %0d bus changes during a byte, required 0", unstable_cnt);
    end
  endtask

  task automatic test_signed();
    logic [15:0]  res_tab[3] = '{16'hFFF9, 16'h8000, 16'h7FFF};
    logic [127:0] l2_tab[3]  = '{"-00007          ", "-32768          ", "+32767          "};
    logic [305:0] f, e;
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      pulse(3'b011, 4'b1111, res_tab[i]);
      wait_idle(2000, "signed");
      e = pack_frame("SUB  [1111]     ", l2_tab[i]);
      pop_bytes(34, f);
      checks++;
      if (f !== e) begin
        failures++;
        $display("FAIL signed_frame_%h: got %h required %h", res_tab[i], f, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [305:0] f, e;
    clear_logs();
    pulse(3'b010, 4'b1010, 16'd100);
    repeat (40) @(negedge clk);
    pulse(3'b010, 4'b1010, 16'd1);
    repeat (10) @(negedge clk);
    pulse(3'b010, 4'b1010, 16'd2);
    repeat (10) @(negedge clk);
    pulse(3'b010, 4'b1010, 16'd3);
    wait_idle(3000, "b2b");
    checks++;
    if (got_q.size() != 68) begin
      failures++;
      $display("FAIL b2b_count: got %0d bytes, required 68", got_q.size());
    end
    e = pack_frame("ADDI [1010]     ", "+00100          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL b2b_first: got %h required %h", f, e);
    end
    e = pack_frame("ADDI [1010]     ", "+00003          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL b2b_second: got %h required %h", f, e);
    end
  endtask

  task automatic test_last_cycle_pulse();
    logic [305:0] f, e;
    logic pe;
    int falls;
    clear_logs();
    pulse(3'b101, 4'b0110, 16'd500);
    pe = lcd_e;
    falls = 0;
    for (int i = 0; i < 2000 && falls < 34; i++) begin
      @(negedge clk);
      if (pe === 1'b1 && lcd_e === 1'b0) falls++;
      pe = lcd_e;
    end
    checks++;
    if (falls != 34) begin
      failures++;
      $display("FAIL last_falls: saw %0d E falls, required 34", falls);
    end
    repeat (T_CMD - 1) @(negedge clk);
    op_selc = 3'b111;
    logger = 4'b0001;
    result = 16'hFFFF;
    btn_send = 1'b1;
    @(negedge clk);
    btn_send = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL last_pended: busy=%b after final-cycle pulse, required 1", busy);
    end
    wait_idle(3000, "last");
    e = pack_frame("MUL  [0110]     ", "+00500          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL last_first: got %h required %h", f, e);
    end
    e = pack_frame("DPL  [0001]     ", "-00001          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL last_second: got %h required %h", f, e);
    end
  endtask

  task automatic test_init_pend();
    int n;
    logic [305:0] f, e;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    release_reset(n);
    pulse(3'b110, 4'b0000, 16'd0);
    wait_idle(3000, "init_pend");
    checks++;
    if (got_q.size() != 38) begin
      failures++;
      $display("FAIL pend_count: got %0d bytes, required 38", got_q.size());
    end
    pop_bytes(4, f);
    checks++;
    if (f[305 -: 36] !== INIT_BYTES) begin
      failures++;
      $display("FAIL pend_init: got %h required %h", f[305 -: 36], INIT_BYTES);
    end
    e = pack_frame("CLR  [0000]     ", "+00000          ");
    pop_bytes(34, f);
    checks++;
    if (f !== e) begin
      failures++;
      $display("FAIL pend_frame: got %h required %h", f, e);
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [305:0] f;
    logic pe;
    int falls;
    pulse(3'b000, 4'b1001, 16'd7);
    pe = lcd_e;
    falls = 0;
    for (int i = 0; i < 2000 && !(falls >= 10 && lcd_e === 1'b1); i++) begin
      @(negedge clk);
      if (pe === 1'b1 && lcd_e === 1'b0) falls++;
      pe = lcd_e;
    end
    checks++;
    if (lcd_e !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: lcd_e=%b before reset, required 1", lcd_e);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, lcd_e, lcd_rs, lcd_data} !== 11'h400) begin
      failures++;
      $display("FAIL arst_async: busy,e,rs,data=%h required 400", {busy, lcd_e, lcd_rs, lcd_data});
    end
    repeat (3) @(negedge clk);
    clear_logs();
    release_reset(n);
    checks++;
    if (n !== T_POWERON + 1) begin
      failures++;
      $display("FAIL arst_wait: first E at sample %0d, required %0d", n, T_POWERON + 1);
    end
    wait_idle(500, "arst");
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL arst_count: got %0d bytes, required 4", got_q.size());
    end
    pop_bytes(4, f);
    checks++;
    if (f[305 -: 36] !== INIT_BYTES) begin
      failures++;
      $display("FAIL arst_init: got %h required %h", f[305 -: 36], INIT_BYTES);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame_add();
    test_signed();
    test_back_to_back();
    test_last_cycle_pulse();
    test_init_pend();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
